// File: rtl/store_narrow.sv
// Store-path narrowing unit: turns a 32-bit register value, byte address and access size
// into lane-replicated write data and byte enables for the data memory port. The computed
// request is held in a 2-entry valid/ready buffer, so the outputs come only from registers.
// Optional build macro STORE_OVF_CHECK_EN adds the signed-range overflow flag. When it is
// undefined, out_ovf is tied to 0.
module store_narrow #(
  parameter int unsigned ADDR_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [1:0]        in_size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_wdata,
  output logic [3:0]        out_be,
  output logic              out_misalign,
  output logic              out_ovf
);

  logic [1:0]        lane;
  logic [ADDR_W-1:0] addr_c;
  logic [31:0]       wdata_c;
  logic [3:0]        be_c;
  logic              mis_c;
  logic              ovf_c;

  logic [ADDR_W-1:0] addr_q  [2];
  logic [31:0]       wdata_q [2];
  logic [3:0]        be_q    [2];
  logic              mis_q   [2];
  logic              ovf_q   [2];
  logic [1:0]        count_q;
  logic              wr_ptr_q;
  logic              rd_ptr_q;

  logic accept;
  logic drain;

  assign lane = in_addr[1:0];

  // Word-aligned address: clear the two byte-offset bits.
  always_comb begin
    addr_c       = in_addr;
    addr_c[1:0]  = 2'b00;
  end

  // Lane replication and byte-enable decode. Misaligned or reserved-size requests carry
  // no enables and no data.
  always_comb begin
    wdata_c = 32'h0;
    be_c    = 4'b0000;
    mis_c   = 1'b0;
    unique case (in_size)
      2'b00: begin
        wdata_c = {4{in_data[7:0]}};
        be_c    = BIG_ENDIAN ? (4'b1000 >> lane) : (4'b0001 << lane);
      end
      2'b01: begin
        if (lane[0]) begin
          mis_c = 1'b1;
        end else begin
          wdata_c = {2{in_data[15:0]}};
          if (BIG_ENDIAN) be_c = lane[1] ? 4'b0011 : 4'b1100;
          else            be_c = lane[1] ? 4'b1100 : 4'b0011;
        end
      end
      2'b10: begin
        if (lane != 2'b00) begin
          mis_c = 1'b1;
        end else begin
          wdata_c = in_data;
          be_c    = 4'b1111;
        end
      end
      default: mis_c = 1'b1;
    endcase
  end

`ifdef STORE_OVF_CHECK_EN
  logic byte_fits;
  logic half_fits;

  // A value fits when every bit from the narrowed sign bit upward is equal.
  always_comb begin
    byte_fits = (&in_data[31:7]) | ~(|in_data[31:7]);
    half_fits = (&in_data[31:15]) | ~(|in_data[31:15]);
    ovf_c     = 1'b0;
    if (!mis_c) begin
      if (in_size == 2'b00)      ovf_c = ~byte_fits;
      else if (in_size == 2'b01) ovf_c = ~half_fits;
    end
  end
`else
  assign ovf_c = 1'b0;
`endif

  assign in_ready  = (count_q != 2'd2) && !rst;
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // Buffer state: entries, pointers and occupancy. Reset discards everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= 32'h0;
        be_q[i]    <= 4'b0000;
        mis_q[i]   <= 1'b0;
        ovf_q[i]   <= 1'b0;
      end
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q[wr_ptr_q]  <= addr_c;
        wdata_q[wr_ptr_q] <= wdata_c;
        be_q[wr_ptr_q]    <= be_c;
        mis_q[wr_ptr_q]   <= mis_c;
        ovf_q[wr_ptr_q]   <= ovf_c;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (drain) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({accept, drain})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_addr     = addr_q[rd_ptr_q];
  assign out_wdata    = wdata_q[rd_ptr_q];
  assign out_be       = be_q[rd_ptr_q];
  assign out_misalign = mis_q[rd_ptr_q];
  assign out_ovf      = ovf_q[rd_ptr_q];

endmodule

// File: tb/tb_store_narrow.sv
// Scoreboard bench for store_narrow: one little-endian and one big-endian instance are
// driven from the same stimulus. Expected heads are queued per instance and compared by a
// monitor on the falling edge.
module tb_store_narrow;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] eaddr;
    logic [31:0] wdata;
    logic [3:0]  be_le;
    logic [3:0]  be_be;
    logic        mis;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        mis;
    logic        ovf;
    int          push_cyc;
    bit          chk_lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] in_addr;
  logic [1:0]  in_size;
  logic        out_ready;

  logic        o_in_ready [2];
  logic        o_valid    [2];
  logic [31:0] o_addr     [2];
  logic [31:0] o_wdata    [2];
  logic [3:0]  o_be       [2];
  logic        o_mis      [2];
  logic        o_ovf      [2];

  exp_t q [2][$];
  vec_t vt [10];
  int   n_chk;
  int   n_pass;
  int   cyc;
  bit   lat_mode;

  store_narrow #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready[0]),
    .in_data(in_data), .in_addr(in_addr), .in_size(in_size),
    .out_valid(o_valid[0]), .out_ready(out_ready), .out_addr(o_addr[0]),
    .out_wdata(o_wdata[0]), .out_be(o_be[0]), .out_misalign(o_mis[0]), .out_ovf(o_ovf[0])
  );

  store_narrow #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready[1]),
    .in_data(in_data), .in_addr(in_addr), .in_size(in_size),
    .out_valid(o_valid[1]), .out_ready(out_ready), .out_addr(o_addr[1]),
    .out_wdata(o_wdata[1]), .out_be(o_be[1]), .out_misalign(o_mis[1]), .out_ovf(o_ovf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic [31:0] data, input logic [31:0] addr,
                              input logic [1:0] size, input logic [31:0] eaddr,
                              input logic [31:0] wdata, input logic [3:0] be_le,
                              input logic [3:0] be_be, input logic mis, input logic ovf);
    vec_t v;
    v.data = data; v.addr = addr; v.size = size; v.eaddr = eaddr; v.wdata = wdata;
    v.be_le = be_le; v.be_be = be_be; v.mis = mis; v.ovf = ovf;
    return v;
  endfunction

  // Present a request and hold it until accepted; the expectation is queued on acceptance.
  task automatic send(input vec_t v);
    bit done;
    exp_t e;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = v.data;
    in_addr  = v.addr;
    in_size  = v.size;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (lat_mode) check("steady_in_ready", {127'h0, o_in_ready[0]}, 128'h1);
      if (o_in_ready[0]) begin
        for (int k = 0; k < 2; k++) begin
          e.addr     = v.eaddr;
          e.wdata    = v.wdata;
          e.be       = (k == 0) ? v.be_le : v.be_be;
          e.mis      = v.mis;
`ifdef STORE_OVF_CHECK_EN
          e.ovf      = v.ovf;
`else
          e.ovf      = 1'b0;
`endif
          e.push_cyc = cyc;
          e.chk_lat  = lat_mode;
          q[k].push_back(e);
        end
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 128'h0, 128'h1);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int t = 0; t < 20 && (q[0].size() + q[1].size()) != 0; t++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", q[0].size() + q[1].size(), 0);
  endtask

  // Monitor: the head must match the oldest expectation every cycle it is valid.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (o_valid[k]) begin
          if (q[k].size() == 0) begin
            check("spurious_valid", {127'h0, o_valid[k]}, 128'h0);
          end else begin
            check(k == 0 ? "head_le" : "head_be",
                  {58'h0, o_addr[k], o_wdata[k], o_be[k], o_mis[k], o_ovf[k]},
                  {58'h0, q[k][0].addr, q[k][0].wdata, q[k][0].be, q[k][0].mis, q[k][0].ovf});
            if (out_ready) begin
              if (q[k][0].chk_lat) check("latency", cyc - q[k][0].push_cyc, 1);
              void'(q[k].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; lat_mode = 1'b0;
    vt[0] = mk(32'h000000A5, 32'h1003, 2'b00, 32'h1000, 32'hA5A5A5A5, 4'b1000, 4'b0001, 0, 1);
    vt[1] = mk(32'hFFFF8001, 32'h2002, 2'b01, 32'h2000, 32'h80018001, 4'b1100, 4'b0011, 0, 0);
    vt[2] = mk(32'hFFFF8001, 32'h2001, 2'b01, 32'h2000, 32'h00000000, 4'b0000, 4'b0000, 1, 0);
    vt[3] = mk(32'hDEADBEEF, 32'h3000, 2'b10, 32'h3000, 32'hDEADBEEF, 4'b1111, 4'b1111, 0, 0);
    vt[4] = mk(32'hDEADBEEF, 32'h3002, 2'b10, 32'h3000, 32'h00000000, 4'b0000, 4'b0000, 1, 0);
    vt[5] = mk(32'h00000011, 32'h4000, 2'b11, 32'h4000, 32'h00000000, 4'b0000, 4'b0000, 1, 0);
    vt[6] = mk(32'h12345678, 32'h5001, 2'b00, 32'h5000, 32'h78787878, 4'b0010, 4'b0100, 0, 1);
    vt[7] = mk(32'h00001234, 32'h6000, 2'b01, 32'h6000, 32'h12341234, 4'b0011, 4'b1100, 0, 0);
    vt[8] = mk(32'hFFFFFF80, 32'h7002, 2'b00, 32'h7000, 32'h80808080, 4'b0100, 4'b0010, 0, 0);
    vt[9] = mk(32'h00008000, 32'h8000, 2'b01, 32'h8000, 32'h80008000, 4'b0011, 4'b1100, 0, 1);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_addr = '0; in_size = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("in_ready_in_rst", {127'h0, o_in_ready[0]}, 128'h0);
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_in_ready", {127'h0, o_in_ready[k]}, 128'h1);
      check("rst_outputs", {58'h0, o_valid[k], o_addr[k], o_wdata[k], o_be[k], o_mis[k], o_ovf[k]},
            128'h0);
    end
    @(posedge clk);
    #1;

    // Fill both entries, then reset: nothing may be issued afterwards.
    out_ready = 1'b0;
    send(vt[0]);
    send(vt[1]);
    @(negedge clk);
    check("full_in_ready", {127'h0, o_in_ready[0]}, 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q[0].delete();
    q[1].delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_valid_le", {127'h0, o_valid[0]}, 128'h0);
    check("flush_valid_be", {127'h0, o_valid[1]}, 128'h0);
    @(posedge clk);
    #1;

    // Directed lane and misalignment vectors, streamed back to back.
    for (int i = 0; i < 10; i++) send(vt[i]);
    wait_empty();

    // Backpressure: two accepted, third blocked, then drained in order.
    out_ready = 1'b0;
    send(vt[6]);
    send(vt[7]);
    in_valid = 1'b1;
    in_data  = vt[8].data;
    in_addr  = vt[8].addr;
    in_size  = vt[8].size;
    @(negedge clk);
    check("bp_third_blocked", {127'h0, o_in_ready[0]}, 128'h0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(vt[8]);
    wait_empty();

    // Steady state at one entry: accept and drain together every cycle.
    out_ready = 1'b0;
    send(vt[3]);
    out_ready = 1'b1;
    lat_mode  = 1'b1;
    for (int j = 0; j < 8; j++) send(vt[(4 + j) % 10]);
    lat_mode = 1'b0;
    wait_empty();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/store_narrow.md
Name: store_narrow

Overview:
- Store-path narrowing unit; the inverse of the immediate/load sign-extension path.
- Takes a 32-bit register value plus a byte address and access size from the MEM stage.
- Produces lane-replicated write data, byte enables, a word-aligned address, a misalignment flag and a signed-range overflow flag for the data memory port.
- Decouples the pipeline from memory through a registered 2-entry valid/ready buffer.

Parameters:
- ADDR_W, 32, address width in bits (minimum 2).
- BIG_ENDIAN, 0, byte-lane order: 0 = little-endian, 1 = big-endian.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  upstream request valid
- in_ready  output  1  buffer can accept a request
- in_data  input  32  register value to store
- in_addr  input  ADDR_W  byte address
- in_size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- out_valid  output  1  request available to memory
- out_ready  input  1  memory accepts request
- out_addr  output  ADDR_W  {in_addr[ADDR_W-1:2], 2'b00}
- out_wdata  output  32  lane-replicated write data
- out_be  output  4  byte enables, bit i = byte lane i (bits [8i+7:8i])
- out_misalign  output  1  request is misaligned or uses the reserved size
- out_ovf  output  1  value not representable in the access width

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high on rst.
  - Reset clears count to 0 and drives out_valid=0, out_wdata=0, out_be=0, out_addr=0, out_misalign=0, out_ovf=0.
  - in_ready=0 while rst is high.
  - Reset asserted mid-operation discards all buffered entries; no partial request is issued afterwards.
- Handshake and buffering:
  - A 2-entry FIFO holds the fully computed request: addr, wdata, be, misalign, ovf.
  - in_ready = (count != 2) and !rst, decoded only from registered count.
  - Accept occurs when in_valid & in_ready; drain occurs when out_valid & out_ready.
  - out_valid = (count != 0). Outputs always present the head entry.
  - Latency: a request accepted at edge N appears on outputs after edge N when the FIFO was empty. The outputs are never combinationally derived from the in_* ports.
  - count=1 with accept and drain in the same cycle: count stays 1; the new entry becomes head on the next edge.
  - count=2: accept blocked. A drain in that cycle leaves count=1, and in_ready rises on the next cycle.
  - count=0 with out_ready=1 and no accept: no effect.
  - Head outputs stay stable while out_valid & !out_ready.
  - Write and read pointers are 1 bit each and wrap 1->0.
- Data and lane rules, with a = in_addr[1:0]:
  - Byte: wdata = {4{in_data[7:0]}}. LE: be = 0001 << a. BE: be = 1000 >> a.
  - Half: wdata = {2{in_data[15:0]}}. LE: be = a[1] ? 1100 : 0011. BE: be = a[1] ? 0011 : 1100.
  - Word: wdata = in_data, be = 1111.
- Misalignment:
  - Set for half with a[0]=1, word with a!=00, or size 11.
  - When set: be=0000, wdata=0, misalign=1, ovf=0. The entry is still buffered and issued so the exception path sees it in order.
- out_addr low two bits are always 00.

Optional Feature:
- Macro: STORE_OVF_CHECK_EN.
- Defined:
  - Byte: ovf=1 when in_data[31:7] is not all-equal.
  - Half: ovf=1 when in_data[31:15] is not all-equal.
  - Word: ovf=0.
  - Equivalently, ovf=1 when sign-extending the narrowed value does not reproduce in_data.
  - Flag only; data is still truncated.
- Undefined: out_ovf is tied 0, and no overflow-compare logic is instantiated.

Test Plan:
1. Reset then idle → in_ready=1, out_valid=0, all outputs 0; rst pulsed with count=2 → next cycle out_valid=0.
2. Byte, data=0x000000A5, addr=0x1003, LE → addr=0x1000, wdata=0xA5A5A5A5, be=1000, misalign=0, ovf=1 (with STORE_OVF_CHECK_EN).
3. Half, data=0xFFFF8001, addr=0x2002, BIG_ENDIAN=1 → wdata=0x80018001, be=0011, ovf=0; same request at addr 0x2001 → be=0000, wdata=0, misalign=1.
4. Word, data=0xDEADBEEF, addr=0x3000 → wdata=0xDEADBEEF, be=1111; addr 0x3002 → misalign=1; size=11 at any address → misalign=1.
5. Backpressure: out_ready=0, three back-to-back requests → first two accepted, in_ready=0 on the third; release out_ready → outputs drain in order with no loss or duplication.
6. count=1 with simultaneous accept and drain every cycle for 8 cycles → count stays 1, in_ready stays 1, and each output follows its input by exactly one cycle.
